// File: rtl/ext_mem_responder.sv
// Wait-state memory responder: a program ROM with a preload port and a data RAM,
// both on a shared 8-bit tristate bus. Illegal accesses complete the full handshake.
module ext_mem_responder #(
  parameter int ROM_AW      = 12,
  parameter int RAM_AW      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       addr_bus,
  inout  wire  [7:0]        data_bus,
  input  logic              read_en,
  input  logic              write_en,
  input  logic              memory_select,
  input  logic              PSEN,
  output logic              ready,
  output logic              bus_err,
  input  logic              load_en,
  input  logic [ROM_AW-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt;
  logic [15:0] lat_addr;
  logic        lat_sel, lat_rd, lat_wr, lat_psen_n;
  logic [7:0]  lat_wdata;
  logic [7:0]  rd_data;

  logic [7:0]  rom [2**ROM_AW];
  logic [7:0]  ram [2**RAM_AW];

  logic        req, accept, abort, enter_ack, leave_ack;
  logic [15:0] s_addr;
  logic        s_sel, s_rd, s_wr, s_psen_n;
  logic [7:0]  s_wdata;
  logic        acc_err;
  logic [7:0]  mem_rdata;
  logic        ram_we, rom_we, bus_oe;

  // Handshake: a request is a level on read_en/write_en held until ready is seen;
  // ready stays high until both enables are low, and dropping the enable during
  // the wait phase withdraws the request without side effects.
  assign req       = read_en | write_en;
  assign accept    = (state_q == S_IDLE) && req && !load_en;
  assign abort     = (state_q == S_WAIT) &&
                     ((lat_rd && !read_en) || (lat_wr && !write_en));
  assign enter_ack = (accept && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && !abort && (wait_cnt == 4'd0));
  assign leave_ack = (state_q == S_ACK) && !req;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
      S_WAIT: begin
        if (abort)          state_d = S_IDLE;
        else if (enter_ack) state_d = S_ACK;
      end
      S_ACK:  if (leave_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the access completes on the acceptance edge, so the
  // access is evaluated from live inputs in IDLE and from the latched copy otherwise.
  always_comb begin
    s_addr   = lat_addr;
    s_sel    = lat_sel;
    s_rd     = lat_rd;
    s_wr     = lat_wr;
    s_psen_n = lat_psen_n;
    s_wdata  = lat_wdata;
    if (state_q == S_IDLE) begin
      s_addr   = addr_bus;
      s_sel    = memory_select;
      s_rd     = read_en;
      s_wr     = write_en;
      s_psen_n = PSEN;
      s_wdata  = data_bus;
    end
  end

  always_comb begin
    acc_err = (s_rd && s_wr) ||
              (s_sel ? (|s_addr[15:RAM_AW]) : (|s_addr[15:ROM_AW])) ||
              (!s_sel && s_wr) ||
              (!s_sel && s_rd && s_psen_n);
    mem_rdata = s_sel ? ram[s_addr[RAM_AW-1:0]] : rom[s_addr[ROM_AW-1:0]];
  end

  assign ram_we = enter_ack && s_wr && !acc_err;
  assign rom_we = (state_q == S_IDLE) && load_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_cnt   <= 4'd0;
      lat_addr   <= 16'd0;
      lat_sel    <= 1'b0;
      lat_rd     <= 1'b0;
      lat_wr     <= 1'b0;
      lat_psen_n <= 1'b0;
      lat_wdata  <= 8'd0;
      rd_data    <= 8'd0;
      ready      <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_err <= 1'b0;
      if (accept) begin
        lat_addr   <= addr_bus;
        lat_sel    <= memory_select;
        lat_rd     <= read_en;
        lat_wr     <= write_en;
        lat_psen_n <= PSEN;
        lat_wdata  <= write_en ? data_bus : 8'd0;
        wait_cnt   <= WAIT_INIT;
      end else if ((state_q == S_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (enter_ack) begin
        ready   <= 1'b1;
        bus_err <= acc_err;
        rd_data <= acc_err ? 8'hFF : mem_rdata;
      end else if (leave_ack) begin
        ready <= 1'b0;
      end
    end
  end

  // Arrays are deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && ram_we) ram[s_addr[RAM_AW-1:0]] <= s_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset && rom_we) rom[load_addr] <= load_data;
  end

  assign bus_oe    = (state_q == S_ACK) && lat_rd && !lat_wr && read_en;
  assign data_bus  = bus_oe ? rd_data : 8'hzz;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Bench for ext_mem_responder: directed scenarios plus random accesses checked
// against a byte-array model of ROM/RAM and the access legality rules.
module tb_ext_mem_responder;

  localparam int ROM_AW      = 12;
  localparam int RAM_AW      = 8;
  localparam int WAIT_CYCLES = 2;
  localparam int TIMEOUT     = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       addr_bus;
  wire  [7:0]        data_bus;
  logic              read_en, write_en, memory_select, PSEN;
  logic              ready, bus_err;
  logic              load_en;
  logic [ROM_AW-1:0] load_addr;
  logic [7:0]        load_data;
  logic [1:0]        dbg_state;
  logic              tb_oe;
  logic [7:0]        tb_wdata;

  logic [7:0] m_rom [2**ROM_AW];
  logic [7:0] m_ram [2**RAM_AW];
  logic [7:0] exp_q [$];

  int n_chk = 0;
  int n_err = 0;

  ext_mem_responder #(
    .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .addr_bus(addr_bus), .data_bus(data_bus),
    .read_en(read_en), .write_en(write_en), .memory_select(memory_select),
    .PSEN(PSEN), .ready(ready), .bus_err(bus_err), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .dbg_state(dbg_state)
  );

  // Undriven bus reads back as 8'h00.
  assign data_bus = tb_oe ? tb_wdata : 8'hzz;
  pulldown (data_bus);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: legality from the address map and op type, then a plain array access.
  task automatic model(input logic rd, input logic wr, input logic sel,
                       input logic [15:0] addr, input logic [7:0] wdata,
                       input logic psen_n, output logic err, output logic [7:0] d);
    logic in_range;
    in_range = sel ? (int'(addr) < (1 << RAM_AW)) : (int'(addr) < (1 << ROM_AW));
    err = (rd && wr) || !in_range || (!sel && wr) || (!sel && rd && psen_n);
    d = 8'hFF;
    if (!err && rd) d = sel ? m_ram[int'(addr)] : m_rom[int'(addr)];
    if (!err && wr) m_ram[int'(addr)] = wdata;
  endtask

  task automatic idle_inputs();
    read_en = 1'b0; write_en = 1'b0; memory_select = 1'b0; PSEN = 1'b0;
    addr_bus = 16'd0; tb_oe = 1'b0; tb_wdata = 8'd0;
    load_en = 1'b0; load_addr = '0; load_data = 8'd0;
  endtask

  task automatic rom_load(input logic [ROM_AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    m_rom[a] = d;
  endtask

  task automatic access(input logic rd, input logic wr, input logic sel,
                        input logic [15:0] addr, input logic [7:0] wdata,
                        input logic psen_n, input logic with_load,
                        input logic [ROM_AW-1:0] laddr, input logic [7:0] ldata);
    logic       exp_err, early_err;
    logic [7:0] exp_d;
    int         cyc;
    if (with_load) m_rom[laddr] = ldata;
    model(rd, wr, sel, addr, wdata, psen_n, exp_err, exp_d);
    exp_q.push_back(exp_d);
    @(negedge clk);
    addr_bus = addr; memory_select = sel; PSEN = psen_n;
    read_en = rd; write_en = wr; tb_oe = wr; tb_wdata = wdata;
    load_en = with_load; load_addr = laddr; load_data = ldata;
    cyc = 0;
    early_err = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      load_en = 1'b0;
      if (cyc >= (with_load ? 2 : 1)) tb_oe = 1'b0;
      if (bus_err && !ready) early_err = 1'b1;
    end while (!ready && cyc < TIMEOUT);
    check("latency", cyc, WAIT_CYCLES + 2 + int'(with_load));
    check("bus_err_on_ack", bus_err, exp_err);
    check("no_err_in_wait", early_err, 1'b0);
    exp_d = exp_q.pop_front();
    check("read_data", data_bus, (rd && !wr) ? exp_d : 8'h00);
    @(negedge clk);
    check("bus_err_pulse", bus_err, 1'b0);
    check("ready_hold", ready, 1'b1);
    read_en = 1'b0; write_en = 1'b0;
    #1;
    check("bus_release", data_bus, 8'h00);
    @(negedge clk);
    check("ready_drop", ready, 1'b0);
  endtask

  task automatic acc(input logic rd, input logic wr, input logic sel,
                     input logic [15:0] addr, input logic [7:0] wdata, input logic psen_n);
    access(rd, wr, sel, addr, wdata, psen_n, 1'b0, '0, 8'd0);
  endtask

  // Request withdrawn during the wait phase: no ready, no memory write.
  task automatic aborted_write(input logic [15:0] addr, input logic [7:0] wdata);
    logic saw_ready;
    @(negedge clk);
    addr_bus = addr; memory_select = 1'b1; write_en = 1'b1; tb_oe = 1'b1; tb_wdata = wdata;
    @(negedge clk);
    tb_oe = 1'b0;
    @(negedge clk);
    write_en = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ready || bus_err) saw_ready = 1'b1;
    end
    check("abort_no_ready", saw_ready, 1'b0);
  endtask

  task automatic reset_in_wait(input logic [15:0] addr, input logic [7:0] wdata);
    @(negedge clk);
    addr_bus = addr; memory_select = 1'b1; write_en = 1'b1; tb_oe = 1'b1; tb_wdata = wdata;
    @(negedge clk);
    tb_oe = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_wait_ready", ready, 1'b0);
    check("rst_wait_err", bus_err, 1'b0);
    check("rst_wait_bus", data_bus, 8'h00);
    @(negedge clk);
    write_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic reset_in_ack(input logic [15:0] addr);
    logic       e;
    logic [7:0] d;
    int         cyc;
    model(1'b1, 1'b0, 1'b1, addr, 8'd0, 1'b0, e, d);
    @(negedge clk);
    addr_bus = addr; memory_select = 1'b1; read_en = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ready && cyc < TIMEOUT);
    check("rst_ack_data", data_bus, d);
    #2 reset = 1'b0;
    #1;
    check("rst_ack_bus", data_bus, 8'h00);
    check("rst_ack_ready", ready, 1'b0);
    @(negedge clk);
    read_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0]        pre0, ram50;
    logic              rd, wr, sel, psen_n, wl;
    logic [15:0]       a;
    logic [ROM_AW-1:0] la;
    int                r;

    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", ready, 1'b0);
    check("reset_err", bus_err, 1'b0);
    check("reset_bus", data_bus, 8'h00);
    reset = 1'b1;

    for (int i = 0; i < 64; i++) rom_load(ROM_AW'(i), 8'($urandom_range(1, 255)));
    rom_load(12'h010, 8'h22);
    pre0 = m_rom[0];
    for (int i = 0; i < 32; i++) acc(1'b0, 1'b1, 1'b1, 16'(i), 8'($urandom_range(1, 255)), 1'b0);

    // ROM read of a preloaded byte, then RAM write/read-back.
    acc(1'b1, 1'b0, 1'b0, 16'h0010, 8'd0, 1'b0);
    acc(1'b0, 1'b1, 1'b1, 16'h0050, 8'hA5, 1'b0);
    acc(1'b1, 1'b0, 1'b1, 16'h0050, 8'd0, 1'b0);
    // ROM write is rejected and leaves the ROM intact.
    acc(1'b0, 1'b1, 1'b0, 16'h0000, 8'h33, 1'b0);
    acc(1'b1, 1'b0, 1'b0, 16'h0000, 8'd0, 1'b0);
    check("rom0_intact", m_rom[0], pre0);
    // Out-of-range RAM and ROM-with-PSEN-high reads.
    acc(1'b1, 1'b0, 1'b1, 16'h0100, 8'd0, 1'b0);
    acc(1'b1, 1'b0, 1'b0, 16'h0020, 8'd0, 1'b1);
    acc(1'b1, 1'b0, 1'b0, 16'h1000, 8'd0, 1'b0);
    // Simultaneous read and write.
    ram50 = m_ram[8'h50];
    acc(1'b1, 1'b1, 1'b1, 16'h0050, 8'h5A, 1'b0);
    acc(1'b1, 1'b0, 1'b1, 16'h0050, 8'd0, 1'b0);
    check("ram50_kept", m_ram[8'h50], ram50);
    // Load coinciding with a request on the same ROM address.
    access(1'b1, 1'b0, 1'b0, 16'h0005, 8'd0, 1'b0, 1'b1, 12'h005, 8'h6C);

    aborted_write(16'h0003, 8'hE7);
    acc(1'b1, 1'b0, 1'b1, 16'h0003, 8'd0, 1'b0);
    reset_in_wait(16'h0010, 8'h77);
    acc(1'b1, 1'b0, 1'b1, 16'h0010, 8'd0, 1'b0);
    reset_in_ack(16'h0007);
    acc(1'b1, 1'b0, 1'b1, 16'h0007, 8'd0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      r   = $urandom_range(0, 9);
      rd  = (r <= 5) || (r == 9);
      wr  = (r >= 6);
      sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        a = sel ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(4096, 65535));
      else
        a = sel ? 16'($urandom_range(0, 31)) : 16'($urandom_range(0, 63));
      psen_n = ($urandom_range(0, 7) == 0);
      wl     = ($urandom_range(0, 7) == 0);
      la     = ROM_AW'($urandom_range(0, 63));
      access(rd, wr, sel, a, 8'($urandom_range(0, 255)), psen_n, wl, la,
             8'($urandom_range(1, 255)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ext_mem_responder.md
EXT_MEM_RESPONDER -- requirements
Module: ext_mem_responder

Interface
REQ-001 Parameter ROM_AW, 12, program ROM address width (4096 bytes).
REQ-002 Parameter RAM_AW, 8, data RAM address width (256 bytes).
REQ-003 Parameter WAIT_CYCLES, 2, wait states inserted before ready (0..15).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 addr_bus  input  16  access address from CPU.
REQ-007 data_bus  inout  8  shared data bus; driven only as in REQ-020, else high-Z.
REQ-008 read_en  input  1  CPU read request, level, active-high.
REQ-009 write_en  input  1  CPU write request, level, active-high.
REQ-010 memory_select  input  1  1 = data RAM, 0 = program ROM.
REQ-011 PSEN  input  1  program store enable, active-low; qualifies ROM reads.
REQ-012 ready  output  1  access complete: read data valid or write committed.
REQ-013 bus_err  output  1  one-cycle pulse flagging an illegal access.
REQ-014 load_en  input  1  ROM preload strobe.
REQ-015 load_addr  input  ROM_AW  ROM preload address.
REQ-016 load_data  input  8  ROM preload data.

Function
REQ-017 FSM states IDLE, WAIT, ACK; one request in flight at a time.
REQ-018 In IDLE, read_en or write_en high: latch addr_bus, memory_select, op type, and data_bus (writes only); load wait counter with WAIT_CYCLES; enter WAIT (ACK directly if WAIT_CYCLES = 0).
REQ-019 In WAIT, counter decrements once per cycle; at zero, enter ACK next edge; read_en/write_en dropping in WAIT aborts to IDLE with no memory write, no ready.
REQ-020 In ACK: ready = 1; for a read, data_bus driven with latched read data while read_en is high; driver released combinationally when read_en falls.
REQ-021 Write commits to RAM on the WAIT->ACK (or IDLE->ACK) edge using the data latched at acceptance.
REQ-022 ACK held until both read_en and write_en are low; then IDLE, ready = 0 on the same edge; no new request accepted in that cycle.
REQ-023 Read latency from request acceptance to ready = WAIT_CYCLES + 1 cycles.
REQ-024 RAM access with addr_bus[15:RAM_AW] nonzero: bus_err, read returns 8'hFF, write discarded.
REQ-025 ROM access with addr_bus[15:ROM_AW] nonzero, or ROM read with PSEN high: bus_err, read returns 8'hFF.
REQ-026 Write with memory_select = 0 (ROM): bus_err, ROM unchanged.
REQ-027 read_en and write_en both high at acceptance: bus_err, no memory change, read data 8'hFF, bus not driven.
REQ-028 All illegal accesses still complete the full WAIT/ACK handshake; bus_err pulses for exactly one cycle on entry to ACK.
REQ-029 load_en honoured only in IDLE: writes load_data to ROM[load_addr]; if a CPU request coincides, load wins, request accepted next cycle; load_en outside IDLE ignored.
REQ-030 ROM and RAM array contents are not cleared by reset.

Reset
REQ-031 reset low forces IDLE asynchronously: ready = 0, bus_err = 0, data_bus high-Z, wait counter = 0, latched request cleared.
REQ-032 Reset asserted mid-access (WAIT or ACK) abandons it; a write not yet committed is not performed.
REQ-033 After reset release, the first request is accepted on the first rising edge with read_en or write_en high.

Verification
REQ-034 Preload ROM[0x010] = 8'h22; read addr 0x0010, memory_select 0, PSEN 0 -> ready 3 cycles after acceptance, data_bus = 8'h22, high-Z after read_en falls.
REQ-035 Write RAM 0x0050 with 8'hA5, then read 0x0050 with memory_select 1 -> read returns 8'hA5, bus_err never asserted.
REQ-036 Write 8'h33 with memory_select 0 at 0x0000 -> bus_err one-cycle pulse, ready asserted, subsequent ROM read of 0x0000 returns preloaded value.
REQ-037 RAM read at 0x0100, and ROM read with PSEN 1 -> bus_err pulse each, data_bus = 8'hFF.
REQ-038 read_en and write_en high together -> bus_err, ready, data_bus stays high-Z, RAM unchanged.
REQ-039 Reset pulsed during WAIT of a RAM write of 8'h77 to 0x0010 -> ready 0, bus high-Z immediately, RAM[0x10] retains prior value.
